// File: rtl/alu_share_sched.sv
// alu_share_sched: round-robin scheduler sharing one WIDTH-bit ALU among
// NUM_REQ requesters. Single-cycle ops run in EXEC. DIV/MOD run in DIV as a
// restoring divider that takes exactly WIDTH cycles. Results are tagged with
// the issuing requester's index.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. Request side: in_req_valid[i] & out_req_ready[i]. Response side:
// out_rsp_valid & in_rsp_ready. Ready never waits on a handshake on the
// same port. A requester keeps valid and payload stable until it is granted,
// or it withdraws valid.
module alu_share_sched #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 8
) (
    input  logic                     in_clk,
    input  logic                     in_rst_n,
    input  logic [NUM_REQ-1:0]       in_req_valid,
    input  logic [3*NUM_REQ-1:0]     in_req_op,
    input  logic [WIDTH*NUM_REQ-1:0] in_req_a,
    input  logic [WIDTH*NUM_REQ-1:0] in_req_b,
    output logic [NUM_REQ-1:0]       out_req_ready,
    output logic                     out_rsp_valid,
    input  logic                     in_rsp_ready,
    output logic [WIDTH-1:0]         out_rsp_data,
    output logic [2:0]               out_rsp_id,
    output logic                     out_rsp_div0,
    output logic                     out_busy
);
    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_MUL = 3'd2;
    localparam logic [2:0] OP_AND = 3'd3;
    localparam logic [2:0] OP_OR  = 3'd4;
    localparam logic [2:0] OP_XOR = 3'd5;
    localparam logic [2:0] OP_DIV = 3'd6;
    localparam logic [2:0] OP_MOD = 3'd7;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_DIV  = 2'd2,
        S_RESP = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [PW-1:0]    ptr_q, ptr_d;
    logic [2:0]       op_q;
    logic [WIDTH-1:0] a_q, b_q;
    logic [PW-1:0]    id_q;
    logic [WIDTH-1:0] rem_q, quo_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] rsp_data_q;
    logic [2:0]       rsp_id_q;
    logic             rsp_div0_q;

    logic             any_valid;
    logic [PW-1:0]    win_idx;
    logic [PW-1:0]    cand;
    logic [2:0]       sel_op;
    logic [WIDTH-1:0] sel_a, sel_b;
    logic             req_hs;
    logic [WIDTH-1:0] alu_res;
    logic [WIDTH:0]   rem_sh, rem_diff;
    logic [WIDTH-1:0] rem_nx, quo_nx;
    logic             div_last;

    // Round-robin pick. The loop runs from lowest to highest priority, so the
    // candidate nearest to pointer+1 overwrites the others and wins.
    always_comb begin
        any_valid = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            cand = PW'((int'(ptr_q) + k) % NUM_REQ);
            if (in_req_valid[cand]) begin
                any_valid = 1'b1;
                win_idx   = cand;
            end
        end
    end

    // Route the winner's payload to the latch inputs.
    always_comb begin
        sel_op = '0;
        sel_a  = '0;
        sel_b  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (win_idx == PW'(i)) begin
                sel_op = in_req_op[3*i +: 3];
                sel_a  = in_req_a[WIDTH*i +: WIDTH];
                sel_b  = in_req_b[WIDTH*i +: WIDTH];
            end
        end
    end

    // One-hot grant. It is only high in IDLE and only while out of reset.
    always_comb begin
        out_req_ready = '0;
        if (in_rst_n && (state_q == S_IDLE) && any_valid) begin
            out_req_ready[win_idx] = 1'b1;
        end
    end

    assign req_hs = (state_q == S_IDLE) && any_valid;

    // Single-cycle ALU. The product is truncated to WIDTH bits.
    always_comb begin
        alu_res = '0;
        case (op_q)
            OP_ADD:  alu_res = a_q + b_q;
            OP_SUB:  alu_res = a_q - b_q;
            OP_MUL:  alu_res = a_q * b_q;
            OP_AND:  alu_res = a_q & b_q;
            OP_OR:   alu_res = a_q | b_q;
            OP_XOR:  alu_res = a_q ^ b_q;
            default: alu_res = '0;
        endcase
    end

    // Restoring divider step. B == 0 always subtracts, which gives an
    // all-ones quotient and leaves the remainder equal to A.
    always_comb begin
        rem_sh   = {rem_q, quo_q[WIDTH-1]};
        rem_diff = rem_sh - {1'b0, b_q};
        if (!rem_diff[WIDTH]) begin
            rem_nx = rem_diff[WIDTH-1:0];
            quo_nx = {quo_q[WIDTH-2:0], 1'b1};
        end else begin
            rem_nx = rem_sh[WIDTH-1:0];
            quo_nx = {quo_q[WIDTH-2:0], 1'b0};
        end
    end

    assign div_last = (cnt_q == CW'(WIDTH - 1));

    // Next-state logic. The pointer moves only on a request handshake.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        case (state_q)
            S_IDLE: begin
                if (any_valid) begin
                    ptr_d   = win_idx;
                    state_d = ((sel_op == OP_DIV) || (sel_op == OP_MOD)) ? S_DIV : S_EXEC;
                end
            end
            S_EXEC: state_d = S_RESP;
            S_DIV: begin
                if (div_last) begin
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                if (in_rsp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and pointer registers.
    always_ff @(posedge in_clk) begin
        if (!in_rst_n) begin
            state_q <= S_IDLE;
            ptr_q   <= PW'(NUM_REQ - 1);
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end

    // Operand latch, divider iteration and result registers.
    always_ff @(posedge in_clk) begin
        if (!in_rst_n) begin
            op_q       <= '0;
            a_q        <= '0;
            b_q        <= '0;
            id_q       <= '0;
            rem_q      <= '0;
            quo_q      <= '0;
            cnt_q      <= '0;
            rsp_data_q <= '0;
            rsp_id_q   <= '0;
            rsp_div0_q <= 1'b0;
        end else begin
            if (req_hs) begin
                op_q  <= sel_op;
                a_q   <= sel_a;
                b_q   <= sel_b;
                id_q  <= win_idx;
                rem_q <= '0;
                quo_q <= sel_a;
                cnt_q <= '0;
            end
            if (state_q == S_EXEC) begin
                rsp_data_q <= alu_res;
                rsp_id_q   <= 3'(id_q);
                rsp_div0_q <= 1'b0;
            end
            if (state_q == S_DIV) begin
                rem_q <= rem_nx;
                quo_q <= quo_nx;
                cnt_q <= cnt_q + 1'b1;
                if (div_last) begin
                    rsp_data_q <= (op_q == OP_DIV) ? quo_nx : rem_nx;
                    rsp_id_q   <= 3'(id_q);
                    rsp_div0_q <= (b_q == '0);
                end
            end
        end
    end

    assign out_rsp_valid = (state_q == S_RESP);
    assign out_rsp_data  = rsp_data_q;
    assign out_rsp_id    = rsp_id_q;
    assign out_rsp_div0  = rsp_div0_q;
    assign out_busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_alu_share_sched.sv
// Testbench for alu_share_sched with NUM_REQ=4 and WIDTH=8. Expected values
// come from plain arithmetic on the opcode rules and a round-robin model
// that tracks the pointer.
module tb_alu_share_sched;
    localparam int NR = 4;
    localparam int W  = 8;

    logic              in_clk;
    logic              in_rst_n;
    logic [NR-1:0]     in_req_valid;
    logic [3*NR-1:0]   in_req_op;
    logic [W*NR-1:0]   in_req_a;
    logic [W*NR-1:0]   in_req_b;
    logic [NR-1:0]     out_req_ready;
    logic              out_rsp_valid;
    logic              in_rsp_ready;
    logic [W-1:0]      out_rsp_data;
    logic [2:0]        out_rsp_id;
    logic              out_rsp_div0;
    logic              out_busy;

    int total = 0;
    int bad   = 0;

    logic [W-1:0] exp_q[$];
    logic [W-1:0] eid_q[$];

    alu_share_sched #(.NUM_REQ(NR), .WIDTH(W)) dut (
        .in_clk        (in_clk),
        .in_rst_n      (in_rst_n),
        .in_req_valid  (in_req_valid),
        .in_req_op     (in_req_op),
        .in_req_a      (in_req_a),
        .in_req_b      (in_req_b),
        .out_req_ready (out_req_ready),
        .out_rsp_valid (out_rsp_valid),
        .in_rsp_ready  (in_rsp_ready),
        .out_rsp_data  (out_rsp_data),
        .out_rsp_id    (out_rsp_id),
        .out_rsp_div0  (out_rsp_div0),
        .out_busy      (out_busy)
    );

    // ---------------- clock / reset ----------------
    initial in_clk = 1'b0;
    always #5 in_clk = ~in_clk;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    function automatic logic [W-1:0] ref_alu(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        int r;
        case (op)
            3'd0: r = int'(a) + int'(b);
            3'd1: r = int'(a) - int'(b);
            3'd2: r = int'(a) * int'(b);
            3'd3: r = int'(a & b);
            3'd4: r = int'(a | b);
            3'd5: r = int'(a ^ b);
            3'd6: r = (b == 0) ? 255 : int'(a) / int'(b);
            default: r = (b == 0) ? int'(a) : int'(a) % int'(b);
        endcase
        return W'(r & 255);
    endfunction

    // ---------------- driver tasks ----------------
    task automatic cyc();
        @(posedge in_clk);
        #1;
    endtask

    task automatic drive_req(input int id, input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        in_req_valid[id]       = 1'b1;
        in_req_op[3*id +: 3]   = op;
        in_req_a[W*id +: W]    = a;
        in_req_b[W*id +: W]    = b;
    endtask

    task automatic clear_reqs();
        in_req_valid = '0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        in_rst_n     = 1'b0;
        in_rsp_ready = 1'b1;
        for (int i = 0; i < NR; i++) drive_req(i, 3'(i), 8'(i + 1), 8'(i + 2));
        cyc();
        cyc();
        #1;
        total++; if (out_req_ready !== 4'b0000) begin bad++; $display("FAIL reset_ready got=%b want=0000", out_req_ready); end
        total++; if (out_busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", out_busy); end
        total++; if (out_rsp_valid !== 1'b0) begin bad++; $display("FAIL reset_rsp_valid got=%b want=0", out_rsp_valid); end
        total++; if (out_rsp_data !== 8'h00) begin bad++; $display("FAIL reset_data got=%h want=00", out_rsp_data); end
        total++; if (out_rsp_id !== 3'd0) begin bad++; $display("FAIL reset_id got=%0d want=0", out_rsp_id); end
        total++; if (out_rsp_div0 !== 1'b0) begin bad++; $display("FAIL reset_div0 got=%b want=0", out_rsp_div0); end
        clear_reqs();
        in_rst_n = 1'b1;
        cyc();
    endtask

    int vec_id [6] = '{0, 2, 2, 2, 1, 3};
    int vec_op [6] = '{0, 6, 7, 2, 6, 7};
    int vec_a  [6] = '{8'hF0, 200, 200, 8'h13, 8'h5A, 8'h5A};
    int vec_b  [6] = '{8'h20, 7, 7, 8'h11, 0, 0};

    task automatic test_single_ops();
        int id, n, lat, exp_lat;
        logic [2:0] op;
        logic [W-1:0] a, b, exp_d;
        logic [NR-1:0] exp_g;
        logic exp_z;
        for (int t = 0; t < 30; t++) begin
            if (t < 6) begin
                id = vec_id[t]; op = 3'(vec_op[t]); a = 8'(vec_a[t]); b = 8'(vec_b[t]);
            end else begin
                id = $urandom_range(0, NR - 1);
                op = 3'($urandom_range(0, 7));
                a  = 8'($urandom_range(0, 255));
                b  = ($urandom_range(0, 5) == 0) ? 8'h00 : 8'($urandom_range(0, 255));
            end
            exp_d   = ref_alu(op, a, b);
            exp_z   = (op >= 3'd6) && (b == 0);
            exp_lat = (op >= 3'd6) ? W + 1 : 2;
            exp_g   = 4'(1) << id;
            in_rsp_ready = 1'b1;
            drive_req(id, op, a, b);
            #1;
            n = 0;
            while (out_req_ready === '0 && n < 30) begin cyc(); #1; n++; end
            total++; if (out_req_ready !== exp_g) begin bad++; $display("FAIL op%0d_grant got=%b want=%b", t, out_req_ready, exp_g); end
            cyc();
            clear_reqs();
            #1;
            lat = 1;
            while (out_rsp_valid !== 1'b1 && lat < 40) begin cyc(); #1; lat++; end
            total++; if (lat != exp_lat) begin bad++; $display("FAIL op%0d_latency got=%0d want=%0d", t, lat, exp_lat); end
            total++; if (out_rsp_data !== exp_d) begin bad++; $display("FAIL op%0d_data op=%0d a=%h b=%h got=%h want=%h", t, op, a, b, out_rsp_data, exp_d); end
            total++; if (out_rsp_id !== 3'(id)) begin bad++; $display("FAIL op%0d_id got=%0d want=%0d", t, out_rsp_id, id); end
            total++; if (out_rsp_div0 !== exp_z) begin bad++; $display("FAIL op%0d_div0 got=%b want=%b", t, out_rsp_div0, exp_z); end
            cyc();
            #1;
            total++; if (out_busy !== 1'b0) begin bad++; $display("FAIL op%0d_idle_after got=%b want=0", t, out_busy); end
        end
    endtask

    task automatic test_round_robin();
        logic [2:0] rop [NR];
        logic [W-1:0] ra [NR];
        logic [W-1:0] rb [NR];
        int ptr_m, w, c, nrsp, cycles;
        logic [W-1:0] ed, ei;
        rop = '{3'd0, 3'd2, 3'd5, 3'd7};
        in_rst_n = 1'b0;
        clear_reqs();
        cyc();
        in_rst_n = 1'b1;
        ptr_m = NR - 1;
        exp_q.delete();
        eid_q.delete();
        for (int i = 0; i < NR; i++) begin
            ra[i] = 8'($urandom_range(0, 255));
            rb[i] = 8'($urandom_range(1, 255));
            drive_req(i, rop[i], ra[i], rb[i]);
        end
        in_rsp_ready = 1'b1;
        nrsp = 0;
        cycles = 0;
        while (nrsp < 6 && cycles < 300) begin
            #1;
            total++; if ($countones(out_req_ready) > 1) begin bad++; $display("FAIL rr_onehot got=%b", out_req_ready); end
            if (out_req_ready !== '0) begin
                w = -1;
                for (int k = 1; k <= NR; k++) begin
                    c = (ptr_m + k) % NR;
                    if (w < 0 && in_req_valid[c]) w = c;
                end
                total++; if (out_req_ready !== (4'(1) << w)) begin bad++; $display("FAIL rr_grant got=%b want=%b", out_req_ready, 4'(1) << w); end
                exp_q.push_back(ref_alu(rop[w], ra[w], rb[w]));
                eid_q.push_back(8'(w));
                ptr_m = w;
            end
            if (out_rsp_valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    total++; bad++; $display("FAIL rr_unexpected_rsp id=%0d", out_rsp_id);
                end else begin
                    ed = exp_q.pop_front();
                    ei = eid_q.pop_front();
                    total++; if (out_rsp_data !== ed) begin bad++; $display("FAIL rr_data got=%h want=%h", out_rsp_data, ed); end
                    total++; if (out_rsp_id !== ei[2:0]) begin bad++; $display("FAIL rr_id got=%0d want=%0d", out_rsp_id, ei); end
                end
                nrsp++;
                if (nrsp == 6) clear_reqs();
            end
            cyc();
            cycles++;
        end
        total++; if (nrsp != 6) begin bad++; $display("FAIL rr_count got=%0d want=6", nrsp); end
        cyc();
    endtask

    task automatic test_back_pressure();
        logic [W-1:0] a, b, a2, b2, exp3, exp1;
        int n;
        a = 8'($urandom_range(0, 255)); b = 8'($urandom_range(0, 255));
        a2 = 8'($urandom_range(0, 255)); b2 = 8'($urandom_range(0, 255));
        exp3 = ref_alu(3'd0, a, b);
        exp1 = ref_alu(3'd5, a2, b2);
        in_rsp_ready = 1'b0;
        drive_req(3, 3'd0, a, b);
        #1;
        n = 0;
        while (out_req_ready === '0 && n < 30) begin cyc(); #1; n++; end
        total++; if (out_req_ready !== 4'b1000) begin bad++; $display("FAIL bp_grant3 got=%b want=1000", out_req_ready); end
        cyc();
        clear_reqs();
        drive_req(1, 3'd5, a2, b2);
        #1;
        n = 0;
        while (out_rsp_valid !== 1'b1 && n < 30) begin cyc(); #1; n++; end
        for (int i = 0; i < 5; i++) begin
            total++; if (out_rsp_valid !== 1'b1) begin bad++; $display("FAIL bp_hold_valid c%0d got=%b want=1", i, out_rsp_valid); end
            total++; if (out_rsp_data !== exp3) begin bad++; $display("FAIL bp_hold_data c%0d got=%h want=%h", i, out_rsp_data, exp3); end
            total++; if (out_rsp_id !== 3'd3) begin bad++; $display("FAIL bp_hold_id c%0d got=%0d want=3", i, out_rsp_id); end
            total++; if (out_req_ready !== 4'b0000) begin bad++; $display("FAIL bp_no_grant c%0d got=%b want=0000", i, out_req_ready); end
            cyc();
            #1;
        end
        in_rsp_ready = 1'b1;
        cyc();
        #1;
        total++; if (out_req_ready !== 4'b0010) begin bad++; $display("FAIL bp_grant1 got=%b want=0010", out_req_ready); end
        cyc();
        clear_reqs();
        #1;
        n = 0;
        while (out_rsp_valid !== 1'b1 && n < 30) begin cyc(); #1; n++; end
        total++; if (out_rsp_data !== exp1) begin bad++; $display("FAIL bp_req1_data got=%h want=%h", out_rsp_data, exp1); end
        total++; if (out_rsp_id !== 3'd1) begin bad++; $display("FAIL bp_req1_id got=%0d want=1", out_rsp_id); end
        cyc();
    endtask

    task automatic test_reset_mid_div();
        logic [W-1:0] a, b, exp0;
        int n, stray;
        a = 8'($urandom_range(0, 255)); b = 8'($urandom_range(0, 255));
        exp0 = ref_alu(3'd0, a, b);
        in_rsp_ready = 1'b1;
        drive_req(0, 3'd6, 8'd200, 8'd7);
        #1;
        n = 0;
        while (out_req_ready === '0 && n < 30) begin cyc(); #1; n++; end
        cyc();
        clear_reqs();
        cyc();
        cyc();
        cyc();
        in_rst_n = 1'b0;
        for (int i = 0; i < NR; i++) drive_req(i, 3'd0, a, b);
        #1;
        total++; if (out_req_ready !== 4'b0000) begin bad++; $display("FAIL rst_ready_low got=%b want=0000", out_req_ready); end
        cyc();
        clear_reqs();
        #1;
        total++; if (out_busy !== 1'b0) begin bad++; $display("FAIL rst_mid_busy got=%b want=0", out_busy); end
        total++; if (out_rsp_valid !== 1'b0) begin bad++; $display("FAIL rst_mid_valid got=%b want=0", out_rsp_valid); end
        in_rst_n = 1'b1;
        stray = 0;
        for (int i = 0; i < W + 4; i++) begin
            cyc();
            #1;
            if (out_rsp_valid === 1'b1) stray++;
        end
        total++; if (stray != 0) begin bad++; $display("FAIL rst_stray_rsp got=%0d want=0", stray); end
        for (int i = 0; i < NR; i++) drive_req(i, 3'd0, a, b);
        #1;
        total++; if (out_req_ready !== 4'b0001) begin bad++; $display("FAIL rst_first_grant got=%b want=0001", out_req_ready); end
        cyc();
        clear_reqs();
        #1;
        n = 0;
        while (out_rsp_valid !== 1'b1 && n < 30) begin cyc(); #1; n++; end
        total++; if (out_rsp_data !== exp0) begin bad++; $display("FAIL rst_after_data got=%h want=%h", out_rsp_data, exp0); end
        total++; if (out_rsp_id !== 3'd0) begin bad++; $display("FAIL rst_after_id got=%0d want=0", out_rsp_id); end
        cyc();
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        in_rst_n     = 1'b0;
        in_req_valid = '0;
        in_req_op    = '0;
        in_req_a     = '0;
        in_req_b     = '0;
        in_rsp_ready = 1'b0;
        test_reset();
        test_single_ops();
        test_round_robin();
        test_back_pressure();
        test_reset_mid_div();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_share_sched.md
# alu_share_sched

Round-robin scheduler that time-shares one 8-bit integer ALU among several requesters. Each requester submits an opcode and two operands with a valid/ready handshake. The block arbitrates, executes the op (single-cycle for add/sub/mul/logic, iterative multi-cycle for div/mod) and returns the result tagged with the requester ID through a valid/ready response port. It sits between the op-issuing front ends and the shared arithmetic datapath.

## Interface
- NUM_REQ, 4, number of requesters (2..8)
- WIDTH, 8, operand/result width
- in_clk  input  1  clock, all state updates on rising edge
- in_rst_n  input  1  synchronous active-low reset
- in_req_valid  input  NUM_REQ  per-requester request valid
- in_req_op  input  3*NUM_REQ  opcode, requester i at [3i+2:3i]
- in_req_a  input  WIDTH*NUM_REQ  operand A, requester i at [WIDTH*i +: WIDTH]
- in_req_b  input  WIDTH*NUM_REQ  operand B, same packing
- out_req_ready  output  NUM_REQ  one-hot grant; at most one bit high
- out_rsp_valid  output  1  result available
- in_rsp_ready  input  1  consumer accepts result
- out_rsp_data  output  WIDTH  result
- out_rsp_id  output  3  index of requester that issued the op
- out_rsp_div0  output  1  DIV/MOD with B == 0
- out_busy  output  1  state != IDLE

## Operation
- Opcodes: 0 ADD, 1 SUB, 2 MUL (low WIDTH bits of product), 3 AND, 4 OR, 5 XOR, 6 DIV (unsigned quotient), 7 MOD (unsigned remainder). All unsigned, results truncated modulo 2^WIDTH.
- FSM states: IDLE, EXEC, DIV, RESP.
- IDLE: if any in_req_valid, grant winner via out_req_ready (combinational from in_req_valid and pointer). Handshake = valid & ready. On handshake latch op, A, B, ID; op 6/7 -> DIV, else -> EXEC. No valid -> stay IDLE, out_req_ready = 0.
- Arbitration: round-robin; search starts at pointer+1 mod NUM_REQ; pointer updated to winner on handshake only. Reset pointer = NUM_REQ-1 (requester 0 has first priority).
- EXEC: compute result into result register, -> RESP.
- DIV: restoring divider, one quotient bit per cycle MSB first, exactly WIDTH cycles; then -> RESP with quotient (op 6) or remainder (op 7).
- B == 0 for DIV/MOD: no special path; divider yields quotient all-ones, remainder = A; out_rsp_div0 = 1. Otherwise out_rsp_div0 = 0.
- RESP: out_rsp_valid = 1; data/id/div0 stable until handshake. in_rsp_ready high -> IDLE; low -> hold.
- out_req_ready = 0 in every state except IDLE.
- Requesters must hold valid/op/operands stable until granted; withdrawal before grant is permitted and simply removes the candidate.

## Timing
- Reset (in_rst_n low at an edge): state IDLE, pointer NUM_REQ-1, out_rsp_valid 0, out_rsp_data 0, out_rsp_id 0, out_rsp_div0 0, out_busy 0. In-flight op discarded, no response. out_req_ready = 0 while in_rst_n low.
- Request accepted in cycle C: non-div op -> out_rsp_valid first high cycle C+2; DIV/MOD -> cycle C+WIDTH+1.
- Response accepted in cycle R -> IDLE in R+1; next grant earliest R+1. Minimum issue spacing 3 cycles (non-div), WIDTH+2 (div).
- Pending requests during busy states are not granted and not lost; they compete at the next IDLE cycle.
- Pointer wrap: winner NUM_REQ-1 -> next search starts at 0.

## Test plan
- Reset then single request req0 ADD A=0xF0 B=0x20, rsp_ready=1 -> grant in accept cycle C, rsp_valid at C+2, data=0x10, id=0, div0=0; IDLE at C+3.
- All four valid continuously with distinct ops -> grants in order 0,1,2,3,0; each response id matches grant, out_req_ready never multi-hot.
- req2 DIV A=200 B=7 -> rsp_valid at C+9, data=28; repeat with MOD -> data=4; MUL A=0x13 B=0x11 -> 0x43.
- DIV A=0x5A B=0 -> data=0xFF, div0=1; MOD A=0x5A B=0 -> data=0x5A, div0=1.
- rsp_ready held low 5 cycles in RESP -> rsp_valid/data/id stable, no grants despite pending req1; grant to req1 the cycle after handshake.
- Assert in_rst_n low midway through a DIV -> next cycle out_busy=0, out_rsp_valid=0, no response for that op; after release req0 wins first.
